// File: rtl/apb_master_requester.sv
// APB3 initiator: turns single-beat local commands into SETUP/ACCESS transfers
// toward up to four slaves, returning one response per accepted command.
module apb_master_requester #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [1:0]            cmd_slave_id,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_W-1:0]     paddr,
    output logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W-1:0]     prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int          CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int unsigned NS    = NUM_SLAVES;
    localparam int unsigned TO    = TIMEOUT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]      wait_cnt, wait_cnt_n, wait_inc;
    logic                  wait_expired;
    logic                  id_ok;
    logic [NUM_SLAVES-1:0] psel_n;
    logic                  penable_n;
    logic                  pwrite_n;
    logic [ADDR_W-1:0]     paddr_n;
    logic [DATA_W-1:0]     pwdata_n;
    logic                  rsp_valid_n;
    logic [DATA_W-1:0]     rsp_rdata_n;
    logic                  rsp_err_n;
    logic                  rsp_timeout_n;

    function automatic logic [NUM_SLAVES-1:0] decode(input logic [1:0] id);
        logic [NUM_SLAVES-1:0] sel;
        sel = '0;
        for (int unsigned i = 0; i < NS; i++) begin
            if ({30'd0, id} == i) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    assign cmd_ready = (state == IDLE) && !rst;
    assign id_ok     = {30'd0, cmd_slave_id} < NS;

    // Saturating increment; the expiry test looks at the post-increment value so
    // the abort fires at the end of the TIMEOUT-th ACCESS cycle with pready low.
    assign wait_inc     = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
    assign wait_expired = (TO != 0) && ({{(32 - CNT_W){1'b0}}, wait_inc} >= TO);

    always_comb begin
        state_n       = state;
        wait_cnt_n    = wait_cnt;
        psel_n        = psel;
        penable_n     = penable;
        pwrite_n      = pwrite;
        paddr_n       = paddr;
        pwdata_n      = pwdata;
        rsp_valid_n   = 1'b0;
        rsp_rdata_n   = '0;
        rsp_err_n     = 1'b0;
        rsp_timeout_n = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    if (id_ok) begin
                        state_n    = SETUP;
                        wait_cnt_n = '0;
                        psel_n     = decode(cmd_slave_id);
                        penable_n  = 1'b0;
                        pwrite_n   = cmd_write;
                        paddr_n    = cmd_addr;
                        pwdata_n   = cmd_write ? cmd_wdata : '0;
                    end else begin
                        state_n = DECERR;
                    end
                end
            end

            SETUP: begin
                state_n   = ACCESS;
                penable_n = 1'b1;
            end

            ACCESS: begin
                if (pready) begin
                    state_n     = IDLE;
                    psel_n      = '0;
                    penable_n   = 1'b0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = pslverr;
                    rsp_rdata_n = (!pwrite && !pslverr) ? prdata : '0;
                end else begin
                    wait_cnt_n = wait_inc;
                    if (wait_expired) begin
                        state_n       = IDLE;
                        psel_n        = '0;
                        penable_n     = 1'b0;
                        rsp_valid_n   = 1'b1;
                        rsp_err_n     = 1'b1;
                        rsp_timeout_n = 1'b1;
                    end
                end
            end

            DECERR: begin
                state_n     = IDLE;
                rsp_valid_n = 1'b1;
                rsp_err_n   = 1'b1;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            psel        <= '0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            psel        <= psel_n;
            penable     <= penable_n;
            pwrite      <= pwrite_n;
            paddr       <= paddr_n;
            pwdata      <= pwdata_n;
            rsp_valid   <= rsp_valid_n;
            rsp_rdata   <= rsp_rdata_n;
            rsp_err     <= rsp_err_n;
            rsp_timeout <= rsp_timeout_n;
        end
    end

endmodule

// File: tb/tb_apb_master_requester.sv
// Directed bench for apb_master_requester: stimulus pushes expected responses into
// a scoreboard queue that a negedge monitor pops whenever rsp_valid is seen.
module tb_apb_master_requester;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 8;
    localparam int NUM_SLAVES = 3;
    localparam int TIMEOUT    = 16;

    logic                  clk;
    logic                  rst;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [1:0]            cmd_slave_id;
    logic [ADDR_W-1:0]     cmd_addr;
    logic [DATA_W-1:0]     cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic [NUM_SLAVES-1:0] psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W-1:0]     prdata;
    logic                  pready;
    logic                  pslverr;

    apb_master_requester #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_SLAVES(NUM_SLAVES),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_slave_id(cmd_slave_id),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        logic       to;
        int         at;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Slave model: waits cfg_waits ACCESS cycles before pready; negative = never.
    int         cfg_waits;
    logic [7:0] cfg_rdata;
    logic       cfg_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin : slave
        int acc;
        acc     = 0;
        pready  = 1'b0;
        prdata  = '0;
        pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (|psel && penable) begin
                pready = (acc == cfg_waits);
                acc++;
            end else begin
                acc    = 0;
                pready = 1'b0;
            end
            prdata  = cfg_rdata;
            pslverr = cfg_err && pready;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, expected no response (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    check("rsp_err", rsp_err, e.err);
                    check("rsp_timeout", rsp_timeout, e.to);
                    check("rsp_cycle", cyc, e.at);
                end
            end else begin
                check("rsp_idle_zero", {rsp_rdata, rsp_err, rsp_timeout}, 0);
            end
            check("psel_onehot", $countones(psel) <= 1, 1);
            check("penable_needs_psel", penable && (psel == '0), 0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // Called at a negedge; returns at the negedge after the accept edge with
    // cmd inputs scrambled (keep=0) or left for the caller to overwrite (keep=1).
    task automatic send(input logic wr, input logic [1:0] id, input logic [7:0] addr,
                        input logic [7:0] wdata, input logic [7:0] e_rdata,
                        input logic e_err, input logic e_to, input int lat,
                        input logic keep, output int hs);
        int b;
        cmd_valid    = 1'b1;
        cmd_write    = wr;
        cmd_slave_id = id;
        cmd_addr     = addr;
        cmd_wdata    = wdata;
        b = 0;
        while (!cmd_ready && b < 100) begin
            @(negedge clk);
            b++;
        end
        check("cmd_accept", cmd_ready, 1);
        hs = cyc;
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            return;
        end
        sb.push_back('{rdata: e_rdata, err: e_err, to: e_to, at: cyc + lat});
        @(negedge clk);
        if (!keep) begin
            cmd_valid    = 1'b0;
            cmd_write    = ~wr;
            cmd_slave_id = ~id;
            cmd_addr     = ~addr;
            cmd_wdata    = ~wdata;
        end
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 60) begin
            @(negedge clk);
            b++;
        end
        check("scoreboard_drain", sb.size(), 0);
        @(negedge clk);
    endtask

    initial begin : stim
        int hs, ha, hb;
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        cmd_write    = 1'b0;
        cmd_slave_id = '0;
        cmd_addr     = '0;
        cmd_wdata    = '0;
        cfg_waits    = 0;
        cfg_rdata    = '0;
        cfg_err      = 1'b0;

        repeat (3) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_psel", psel, 0);
        check("reset_penable", penable, 0);
        check("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0;
        #1;
        check("release_cmd_ready", cmd_ready, 1);
        check("reset_paddr", paddr, 0);
        check("reset_pwdata", pwdata, 0);
        @(negedge clk);

        // Write, zero wait
        cfg_waits = 0;
        send(1'b1, 2'd1, 8'h10, 8'hA5, 8'h00, 1'b0, 1'b0, 3, 1'b0, hs);
        check("wr_setup_psel", psel, 3'b010);
        check("wr_setup_penable", penable, 0);
        check("wr_setup_paddr", paddr, 8'h10);
        check("wr_setup_pwdata", pwdata, 8'hA5);
        check("wr_setup_pwrite", pwrite, 1);
        check("wr_setup_cmd_ready", cmd_ready, 0);
        @(negedge clk);
        check("wr_access_penable", penable, 1);
        check("wr_access_psel", psel, 3'b010);
        check("wr_access_paddr", paddr, 8'h10);
        check("wr_access_pwdata", pwdata, 8'hA5);
        @(negedge clk);
        check("wr_done_psel", psel, 0);
        check("wr_done_penable", penable, 0);
        check("wr_done_cmd_ready", cmd_ready, 1);
        drain();

        // Read with 3 wait states
        cfg_waits = 3;
        cfg_rdata = 8'h3C;
        send(1'b0, 2'd0, 8'h04, 8'h99, 8'h3C, 1'b0, 1'b0, 6, 1'b0, hs);
        check("rd_setup_psel", psel, 3'b001);
        check("rd_setup_pwrite", pwrite, 0);
        check("rd_setup_pwdata", pwdata, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rd_wait_paddr", paddr, 8'h04);
            check("rd_wait_penable", penable, 1);
        end
        drain();

        // PSLVERR on a read
        cfg_waits = 0;
        cfg_rdata = 8'hFF;
        cfg_err   = 1'b1;
        send(1'b0, 2'd2, 8'h20, 8'h00, 8'h00, 1'b1, 1'b0, 3, 1'b0, hs);
        check("err_setup_psel", psel, 3'b100);
        drain();
        cfg_err = 1'b0;

        // Timeout: 16 ACCESS cycles with pready low
        cfg_waits = -1;
        send(1'b0, 2'd0, 8'h30, 8'h00, 8'h00, 1'b1, 1'b1, 18, 1'b0, hs);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("to_access_psel", psel, 3'b001);
            check("to_access_penable", penable, 1);
        end
        @(negedge clk);
        check("to_abort_psel", psel, 0);
        check("to_abort_penable", penable, 0);
        drain();
        cfg_waits = 0;
        cfg_rdata = 8'h5A;
        send(1'b0, 2'd2, 8'h40, 8'h00, 8'h5A, 1'b0, 1'b0, 3, 1'b0, hs);
        drain();

        // Decode error on id 3 with only 3 slaves
        send(1'b1, 2'd3, 8'h50, 8'h77, 8'h00, 1'b1, 1'b0, 2, 1'b0, hs);
        check("dec_psel", psel, 0);
        check("dec_penable", penable, 0);
        drain();

        // Back-to-back: second command held while the first is in flight
        cfg_waits = 0;
        cfg_rdata = 8'h66;
        send(1'b1, 2'd2, 8'h60, 8'h11, 8'h00, 1'b0, 1'b0, 3, 1'b1, ha);
        send(1'b0, 2'd1, 8'h61, 8'h00, 8'h66, 1'b0, 1'b0, 3, 1'b0, hb);
        check("b2b_accept_spacing", hb - ha, 3);
        check("b2b_second_psel", psel, 3'b010);
        check("b2b_second_paddr", paddr, 8'h61);
        drain();

        // Reset during a stalled ACCESS
        cfg_waits = -1;
        send(1'b1, 2'd0, 8'h70, 8'hC3, 8'h00, 1'b0, 1'b0, 3, 1'b0, hs);
        @(negedge clk);
        check("rst_mid_penable", penable, 1);
        sb.delete();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_psel", psel, 0);
        check("rst_mid_penable_low", penable, 0);
        check("rst_mid_pwrite", pwrite, 0);
        check("rst_mid_paddr", paddr, 0);
        check("rst_mid_pwdata", pwdata, 0);
        check("rst_mid_rsp_valid", rsp_valid, 0);
        check("rst_mid_cmd_ready", cmd_ready, 0);
        rst = 1'b0;
        #1;
        check("rst_release_cmd_ready", cmd_ready, 1);
        repeat (4) @(negedge clk);
        cfg_waits = 0;
        cfg_rdata = 8'h81;
        send(1'b0, 2'd1, 8'h71, 8'h00, 8'h81, 1'b0, 1'b0, 3, 1'b0, hs);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_requester.md
Name: apb_master_requester

Overview:
- APB initiator that turns single-beat commands from a local requester (testbench sequencer, CPU model, DMA) into APB3 transfers toward up to four APB slaves.
- Each slave is selected by a 2-bit slave id, for example the APB-to-I2C bridge slaves.
- Implements the SETUP/ACCESS handshake, PREADY wait states, PSLVERR capture, a wait-state timeout and out-of-range slave-id decode errors.
- Returns one response per accepted command.

Parameters:
- ADDR_W, 8, width of PADDR and cmd_addr.
- DATA_W, 8, width of PWDATA/PRDATA and the command/response data.
- NUM_SLAVES, 4, number of implemented PSEL lines (1..4); ids >= NUM_SLAVES are decode errors.
- TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_write  input  1  1 = write, 0 = read.
- cmd_slave_id  input  2  target slave index.
- cmd_addr  input  ADDR_W  target address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  one-cycle response strobe.
- rsp_rdata  output  DATA_W  read data (0 for writes and errors).
- rsp_err  output  1  PSLVERR, decode error or timeout.
- rsp_timeout  output  1  error cause was timeout.
- psel  output  NUM_SLAVES  one-hot APB select.
- penable  output  1  APB enable.
- pwrite  output  1  APB direction.
- paddr  output  ADDR_W  APB address.
- pwdata  output  DATA_W  APB write data.
- prdata  input  DATA_W  read data, muxed from the selected slave.
- pready  input  1  slave ready.
- pslverr  input  1  slave error.

Behaviour:
- All outputs are registered except cmd_ready, which is 1 exactly when state == IDLE and rst == 0.
- Reset (sync, any state including mid-transfer): at the next edge state = IDLE; psel, penable, pwrite, paddr, pwdata, rsp_* and the wait counter all = 0. No response is issued for the aborted command.
- States: IDLE, SETUP, ACCESS, DECERR.
- IDLE: on cmd_valid && cmd_ready, latch the command.
  - If cmd_slave_id < NUM_SLAVES: go to SETUP.
  - Otherwise: go to DECERR.
- SETUP (1 cycle): psel[id] = 1, penable = 0; paddr, pwrite and pwdata driven from the latched command.
  - pwdata = 0 for reads.
  - Next state is ACCESS.
- ACCESS: psel held, penable = 1; paddr, pwrite and pwdata are stable for the whole state.
  - pready = 1: capture prdata (reads only) and pslverr. Next cycle: psel = 0, penable = 0, state = IDLE, rsp_valid = 1, rsp_err = pslverr, rsp_timeout = 0.
    - On error, rsp_rdata = 0.
  - pready = 0: increment the wait counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with pready still 0: next cycle psel = 0, penable = 0, state = IDLE, rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
  - pready = 1 on the same cycle the counter reaches TIMEOUT: completes normally; pready wins.
- DECERR (1 cycle): no psel asserted. Next cycle: IDLE with rsp_valid = 1, rsp_err = 1, rsp_timeout = 0.
- Timing: minimum latency, accept edge to rsp_valid, is 3 cycles (SETUP, ACCESS with pready = 1, response).
  - cmd_ready is high in the response cycle, so back-to-back commands run at 1 per 3 cycles.
  - The PSEL gap between transfers is 1 cycle.
- rsp_valid is a single-cycle pulse with no backpressure; rsp_rdata/rsp_err/rsp_timeout are 0 whenever rsp_valid = 0.
- The wait counter is ceil(log2(TIMEOUT+1)) bits, is cleared on entry to SETUP, and saturates.
- Command inputs are ignored outside the IDLE handshake; changes during a transfer do not affect the APB outputs.
- At most one psel bit is ever high; penable = 1 only when a psel bit is high.

Test Plan:
- Write, zero wait: id = 1, addr = 0x10, wdata = 0xA5, pready tied 1.
  - Cycle+1: psel = 4'b0010, penable = 0, paddr = 0x10, pwdata = 0xA5.
  - Cycle+2: penable = 1.
  - Cycle+3: rsp_valid = 1, rsp_err = 0, psel = 0.
- Read with 3 wait states: id = 0, addr = 0x04; slave holds pready = 0 for 3 ACCESS cycles, then drives prdata = 0x3C with pready = 1.
  - paddr stable throughout; rsp_valid 6 cycles after accept.
  - rsp_rdata = 0x3C, rsp_err = 0.
- PSLVERR: read with pslverr = 1 and prdata = 0xFF at pready -> rsp_err = 1, rsp_rdata = 0x00, rsp_timeout = 0.
- Timeout: TIMEOUT = 16, pready stuck 0 -> after exactly 16 ACCESS cycles psel/penable drop and rsp_err = 1, rsp_timeout = 1.
  - A following command completes normally.
- Decode error and back-to-back: NUM_SLAVES = 3, id = 3 -> psel never asserted, rsp_valid after 2 cycles with rsp_err = 1.
  - Two valid commands held back-to-back -> accepts 3 cycles apart, with correct ordering and one response each.
- Reset mid-transfer: assert rst during ACCESS with pready = 0 -> next edge all outputs 0, cmd_ready = 1 after rst drops, no rsp_valid pulse.
